// File: rtl/ray_receiver.sv
// ray_receiver: buffers incoming rays in a fall-through FIFO, tags them with pixel x/y and linear address, and pulses frame_done after the last pixel drains.
module ray_receiver #(
    parameter int FIFO_DEPTH = 4,
    parameter int DIR_W      = 32,
    parameter int DIM_W      = 13
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [DIM_W-1:0]   image_width,
    input  logic [DIM_W-1:0]   image_height,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DIR_W-1:0]   ray_dir_x,
    input  logic [DIR_W-1:0]   ray_dir_y,
    input  logic [DIR_W-1:0]   ray_dir_z,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DIR_W-1:0]   out_dir_x,
    output logic [DIR_W-1:0]   out_dir_y,
    output logic [DIR_W-1:0]   out_dir_z,
    output logic [DIM_W-1:0]   out_pixel_x,
    output logic [DIM_W-1:0]   out_pixel_y,
    output logic [2*DIM_W-1:0] out_addr,
    output logic               busy,
    output logic               frame_done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
    typedef enum logic [1:0] {IDLE, RECEIVE, DRAIN, DONE} state_t;
    state_t              state_q;
    logic [DIR_W-1:0]    dx_q [FIFO_DEPTH];
    logic [DIR_W-1:0]    dy_q [FIFO_DEPTH];
    logic [DIR_W-1:0]    dz_q [FIFO_DEPTH];
    logic [DIM_W-1:0]    px_q [FIFO_DEPTH];
    logic [DIM_W-1:0]    py_q [FIFO_DEPTH];
    logic [2*DIM_W-1:0]  pa_q [FIFO_DEPTH];
    logic [AW-1:0]       wr_q, rd_q;
    logic [AW:0]         cnt_q;
    logic [DIM_W-1:0]    w_q, h_q, x_q, y_q;
    logic [2*DIM_W-1:0]  addr_q;
    logic                push, pop;
    assign in_ready    = state_q == RECEIVE && cnt_q != DEPTH;
    assign out_valid   = cnt_q != '0;
    assign push        = in_valid && in_ready;
    assign pop         = out_valid && out_ready;
    assign busy        = state_q == RECEIVE || state_q == DRAIN;
    assign frame_done  = state_q == DONE;
    assign out_dir_x   = dx_q[rd_q];
    assign out_dir_y   = dy_q[rd_q];
    assign out_dir_z   = dz_q[rd_q];
    assign out_pixel_x = px_q[rd_q];
    assign out_pixel_y = py_q[rd_q];
    assign out_addr    = pa_q[rd_q];
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            w_q     <= '0;
            h_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                dx_q[i] <= '0;
                dy_q[i] <= '0;
                dz_q[i] <= '0;
                px_q[i] <= '0;
                py_q[i] <= '0;
                pa_q[i] <= '0;
            end
        end else begin
            if (push) begin
                dx_q[wr_q] <= ray_dir_x;
                dy_q[wr_q] <= ray_dir_y;
                dz_q[wr_q] <= ray_dir_z;
                px_q[wr_q] <= x_q;
                py_q[wr_q] <= y_q;
                pa_q[wr_q] <= addr_q;
                wr_q       <= wr_q + AW'(1);
            end
            if (pop) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
            case (state_q)
                IDLE: if (start) begin
                    w_q     <= image_width;
                    h_q     <= image_height;
                    x_q     <= '0;
                    y_q     <= '0;
                    addr_q  <= '0;
                    state_q <= (image_width == '0 || image_height == '0) ? DONE : RECEIVE;
                end
                RECEIVE: if (push) begin
                    addr_q <= addr_q + (2*DIM_W)'(1);
                    if (x_q == w_q - DIM_W'(1)) begin
                        x_q <= '0;
                        y_q <= y_q + DIM_W'(1);
                        if (y_q == h_q - DIM_W'(1)) state_q <= DRAIN;
                    end else begin
                        x_q <= x_q + DIM_W'(1);
                    end
                end
                // the final pop of the frame moves straight to DONE
                DRAIN: if (cnt_q == '0 || (cnt_q == (AW+1)'(1) && pop)) state_q <= DONE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
